// File: rtl/keccak_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keccak_pkg
//  Description : Shared constants and helpers for the slice-serial Keccak
//                theta datapath. A slice holds the 25 bits sharing one z
//                coordinate, with bit index 5*y+x.
//  Revision    : 1.0 - initial release
// ============================================================================
package keccak_pkg;

    localparam int SLICE_BITS = 25;
    localparam int NUM_X      = 5;

    // Position of lane (x,y) inside a 25-bit slice.
    function automatic int bit_idx(input int x, input int y);
        return 5 * y + x;
    endfunction

    // Column parities of one slice: bit x = XOR over y of slice[5y+x].
    function automatic logic [NUM_X-1:0] col_parity(input logic [SLICE_BITS-1:0] s);
        logic [NUM_X-1:0] p;
        p = '0;
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < NUM_X; x++) begin
                p[x] = p[x] ^ s[bit_idx(x, y)];
            end
        end
        return p;
    endfunction

endpackage : keccak_pkg
`default_nettype wire

// File: rtl/keccak_theta_slice.sv
`default_nettype none
// ============================================================================
//  Module      : keccak_theta_slice
//  Description : Combinational theta update of a single slice.
//                out[5y+x] = slice[5y+x] ^ par_cur[(x+4)%5] ^ par_prev[(x+1)%5]
//  Ports       : i_slice    - slice z of the state
//                i_par_cur  - column parities of slice z
//                i_par_prev - column parities of slice z-1 (mod W)
//                o_slice    - theta-updated slice z
//  Revision    : 1.0 - initial release
// ============================================================================
module keccak_theta_slice
    import keccak_pkg::*;
(
    input  logic [SLICE_BITS-1:0] i_slice,
    input  logic [NUM_X-1:0]      i_par_cur,
    input  logic [NUM_X-1:0]      i_par_prev,
    output logic [SLICE_BITS-1:0] o_slice
);

    logic [NUM_X-1:0] w_d;

    always_comb begin
        w_d     = '0;
        o_slice = '0;
        for (int x = 0; x < NUM_X; x++) begin
            w_d[x] = i_par_cur[(x + 4) % 5] ^ i_par_prev[(x + 1) % 5];
        end
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < NUM_X; x++) begin
                o_slice[bit_idx(x, y)] = i_slice[bit_idx(x, y)] ^ w_d[x];
            end
        end
    end

endmodule : keccak_theta_slice
`default_nettype wire

// File: rtl/keccak_theta_stream.sv
`default_nettype none
// ============================================================================
//  Module      : keccak_theta_stream
//  Description : Slice-serial Keccak theta step for Keccak-f[25*W]. Loads the
//                W slices of a state over a valid/ready stream while storing
//                per-slice column parities, then emits theta-updated slices
//                z=0..W-1. Bypass mode returns the loaded state unchanged.
//  Ports       : clk       - clock, rising edge
//                rst       - synchronous active-low reset
//                bypass    - mode request, sampled on first slice of a state
//                in_valid / in_ready / in_slice   - input slice stream
//                out_valid / out_ready / out_slice / out_idx - output stream
//                busy      - high unless idle in LOAD with no slice accepted
//                done      - one-cycle pulse after the last output handshake
//  Revision    : 1.0 - initial release
// ============================================================================
module keccak_theta_stream
    import keccak_pkg::*;
#(
    parameter int W  = 64,
    parameter int ZW = (W > 1) ? $clog2(W) : 1
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bypass,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SLICE_BITS-1:0] in_slice,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SLICE_BITS-1:0] out_slice,
    output logic [ZW-1:0]         out_idx,
    output logic                  busy,
    output logic                  done
);

    // Storage is sized to the full index range so every ZW-bit index is in
    // bounds; for W=1 the extra entry is never addressed.
    localparam int          C_DEPTH   = 1 << ZW;
    localparam logic [ZW-1:0] C_LAST  = ZW'(W - 1);

    localparam logic [0:0]  C_ST_LOAD = 1'b0;
    localparam logic [0:0]  C_ST_EMIT = 1'b1;

    generate
        if (!(W == 1 || W == 2 || W == 4 || W == 8 ||
              W == 16 || W == 32 || W == 64)) begin : g_bad_w
            $error("keccak_theta_stream: W must be a power of two in 1..64");
        end
    endgenerate

    logic [0:0]            r_state;
    logic [ZW-1:0]         r_cnt;
    logic                  r_mode;
    logic                  r_done;
    logic [SLICE_BITS-1:0] r_buf [C_DEPTH];
    logic [NUM_X-1:0]      r_par [C_DEPTH];

    logic                  w_load_hs;
    logic                  w_emit_hs;
    logic [ZW-1:0]         w_zprev;
    logic [SLICE_BITS-1:0] w_cur;
    logic [SLICE_BITS-1:0] w_theta;

    assign w_load_hs = (r_state == C_ST_LOAD) && in_valid;
    assign w_emit_hs = (r_state == C_ST_EMIT) && out_ready;

    // Natural ZW-bit wrap gives (z-1) mod W for W>=2; with a single slice the
    // previous slice is slice 0 itself.
    generate
        if (W == 1) begin : g_prev_w1
            assign w_zprev = '0;
        end else begin : g_prev_wn
            assign w_zprev = r_cnt - ZW'(1);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Control: state, slice counter, mode latch, done pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= C_ST_LOAD;
            r_cnt   <= '0;
            r_mode  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                C_ST_LOAD: begin
                    if (w_load_hs) begin
                        if (r_cnt == '0) begin
                            r_mode <= bypass;
                        end
                        if (r_cnt == C_LAST) begin
                            r_state <= C_ST_EMIT;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + ZW'(1);
                        end
                    end
                end
                C_ST_EMIT: begin
                    if (w_emit_hs) begin
                        if (r_cnt == C_LAST) begin
                            r_state <= C_ST_LOAD;
                            r_cnt   <= '0;
                            r_done  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + ZW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= C_ST_LOAD;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Slice buffer and per-slice column parities (no reset needed)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_load_hs) begin
            r_buf[r_cnt] <= in_slice;
            r_par[r_cnt] <= col_parity(in_slice);
        end
    end

    assign w_cur = r_buf[r_cnt];

    keccak_theta_slice u_theta (
        .i_slice    (w_cur),
        .i_par_cur  (r_par[r_cnt]),
        .i_par_prev (r_par[w_zprev]),
        .o_slice    (w_theta)
    );

    // ------------------------------------------------------------------
    // Outputs: driven only from registers, so no input-to-handshake path.
    // Data and index read as zero outside EMIT.
    // ------------------------------------------------------------------
    always_comb begin
        out_slice = '0;
        out_idx   = '0;
        if (r_state == C_ST_EMIT) begin
            out_slice = r_mode ? w_cur : w_theta;
            out_idx   = r_cnt;
        end
    end

    assign in_ready  = (r_state == C_ST_LOAD);
    assign out_valid = (r_state == C_ST_EMIT);
    assign busy      = (r_state == C_ST_EMIT) || (r_cnt != '0);
    assign done      = r_done;

endmodule : keccak_theta_stream
`default_nettype wire

// File: tb/tb_keccak_theta_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keccak_theta_stream
//  Description : Self-checking bench for keccak_theta_stream (W=64 and W=1).
//                Expected data comes from literal vectors or from a lane-wise
//                theta model (C[x], D[x] = C[x-1] ^ ROT(C[x+1],1)).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keccak_theta_stream;

    typedef logic [24:0] state_t [64];

    logic        clk;
    logic        rst;

    logic        bypass, in_valid, in_ready, out_valid, out_ready, busy, done;
    logic [24:0] in_slice, out_slice;
    logic [5:0]  out_idx;

    logic        s1_bypass, s1_in_valid, s1_in_ready, s1_out_valid;
    logic        s1_out_ready, s1_busy, s1_done;
    logic [24:0] s1_in_slice, s1_out_slice;
    logic [0:0]  s1_out_idx;

    int n_chk  = 0;
    int n_fail = 0;

    keccak_theta_stream #(.W(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .bypass    (bypass),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_slice  (in_slice),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_slice (out_slice),
        .out_idx   (out_idx),
        .busy      (busy),
        .done      (done)
    );

    keccak_theta_stream #(.W(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .bypass    (s1_bypass),
        .in_valid  (s1_in_valid),
        .in_ready  (s1_in_ready),
        .in_slice  (s1_in_slice),
        .out_valid (s1_out_valid),
        .out_ready (s1_out_ready),
        .out_slice (s1_out_slice),
        .out_idx   (s1_out_idx),
        .busy      (s1_busy),
        .done      (s1_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Lane-oriented theta model for a W-bit lane: bit z of lane (x,y) is
    // bit 5y+x of slice z.
    function automatic state_t theta_ref(input state_t s, input int w);
        logic [63:0] lane [5][5];
        logic [63:0] c [5];
        logic [63:0] d [5];
        logic [63:0] mask;
        logic [63:0] r;
        state_t      o;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        for (int x = 0; x < 5; x++) begin
            c[x] = '0;
            for (int y = 0; y < 5; y++) begin
                lane[x][y] = '0;
                for (int z = 0; z < w; z++) lane[x][y][z] = s[z][5*y+x];
                c[x] = c[x] ^ lane[x][y];
            end
        end
        for (int x = 0; x < 5; x++) begin
            r    = ((c[(x+1)%5] << 1) | (c[(x+1)%5] >> (w - 1))) & mask;
            d[x] = c[(x+4)%5] ^ r;
        end
        for (int z = 0; z < 64; z++) begin
            o[z] = '0;
            if (z < w) begin
                for (int y = 0; y < 5; y++)
                    for (int x = 0; x < 5; x++)
                        o[z][5*y+x] = lane[x][y][z] ^ d[x][z];
            end
        end
        return o;
    endfunction

    // Feed 64 slices back-to-back; bypass is only meaningful on slice 0 so
    // it is flipped afterwards to show later values are ignored.
    task automatic load_state(input state_t s, input logic byp);
        for (int z = 0; z < 64; z++) begin
            in_valid = 1'b1;
            in_slice = s[z];
            bypass   = (z == 0) ? byp : ~byp;
            check($sformatf("load_in_ready_z%0d", z), 32'(in_ready), 32'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        bypass   = 1'b0;
        in_slice = '0;
    endtask

    // pat: 0 = out_ready held high, 1 = repeating 1,0,0,1, 2 = random.
    // stop_at >= 0 returns once out_idx reaches that slice (no done check).
    task automatic emit_check(input state_t exp, input int pat, input int stop_at, input logic junk);
        int z = 0;
        int k = 0;
        int budget = 0;
        while (z < 64 && z != stop_at && budget < 400) begin
            case (pat)
                0:       out_ready = 1'b1;
                1:       out_ready = (k % 4 == 0) || (k % 4 == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            k++;
            if (junk) begin
                in_valid = 1'b1;
                in_slice = 25'($urandom);
            end
            check($sformatf("emit_out_valid_z%0d", z), 32'(out_valid), 32'd1);
            check($sformatf("emit_in_ready_z%0d", z), 32'(in_ready), 32'd0);
            check($sformatf("emit_busy_z%0d", z), 32'(busy), 32'd1);
            check($sformatf("emit_out_idx_z%0d", z), 32'(out_idx), 32'(z));
            check($sformatf("emit_out_slice_z%0d", z), 32'(out_slice), 32'(exp[z]));
            @(posedge clk); #1;
            budget++;
            if (out_ready) z++;
        end
        in_valid  = 1'b0;
        in_slice  = '0;
        out_ready = 1'b0;
        if (budget >= 400) check("emit_cycle_budget", 32'(budget), 32'd0);
        if (stop_at < 0) begin
            check("done_pulse", 32'(done), 32'd1);
            check("after_emit_out_valid", 32'(out_valid), 32'd0);
            check("after_emit_in_ready", 32'(in_ready), 32'd1);
        end
    endtask

    task automatic idle_check(input string tag);
        @(posedge clk); #1;
        check({tag, "_done_low"}, 32'(done), 32'd0);
        check({tag, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    initial begin
        state_t s, e;

        rst = 1'b0;
        bypass = 1'b0; in_valid = 1'b0; in_slice = '0; out_ready = 1'b0;
        s1_bypass = 1'b0; s1_in_valid = 1'b0; s1_in_slice = '0; s1_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_slice", 32'(out_slice), 32'd0);
        check("rst_out_idx",   32'(out_idx),   32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_done",      32'(done),      32'd0);
        check("rst_w1_in_ready", 32'(s1_in_ready), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;

        // 1: all-zero state
        for (int z = 0; z < 64; z++) s[z] = '0;
        e = theta_ref(s, 64);
        load_state(s, 1'b0);
        emit_check(e, 0, -1, 1'b0);
        idle_check("t1");

        // 2: single bit in slice 0
        for (int z = 0; z < 64; z++) begin s[z] = '0; e[z] = '0; end
        s[0] = 25'h0000001;
        e[0] = 25'h0210843;
        e[1] = 25'h1084210;
        load_state(s, 1'b0);
        emit_check(e, 0, -1, 1'b0);
        idle_check("t2");

        // 3a: wrap-around from slice 63 into slice 0
        for (int z = 0; z < 64; z++) begin s[z] = '0; e[z] = '0; end
        s[63] = 25'h0000001;
        e[63] = 25'h0210843;
        e[0]  = 25'h1084210;
        load_state(s, 1'b0);
        emit_check(e, 0, -1, 1'b0);
        idle_check("t3");

        // 3b: W=1, both parity terms from slice 0
        s1_in_valid = 1'b1;
        s1_in_slice = 25'h0000001;
        check("w1_in_ready", 32'(s1_in_ready), 32'd1);
        @(posedge clk); #1;
        s1_in_valid = 1'b0;
        check("w1_out_valid", 32'(s1_out_valid), 32'd1);
        check("w1_out_idx",   32'(s1_out_idx),   32'd0);
        check("w1_out_slice", 32'(s1_out_slice), 32'h1294A53);
        s1_out_ready = 1'b1;
        @(posedge clk); #1;
        s1_out_ready = 1'b0;
        check("w1_done",      32'(s1_done),      32'd1);
        check("w1_out_valid_after", 32'(s1_out_valid), 32'd0);

        // 4: backpressure 1,0,0,1 with junk on the input during EMIT
        for (int z = 0; z < 64; z++) begin s[z] = '0; e[z] = '0; end
        s[0] = 25'h0000001;
        e[0] = 25'h0210843;
        e[1] = 25'h1084210;
        load_state(s, 1'b0);
        emit_check(e, 1, -1, 1'b1);
        idle_check("t4");

        // 5: bypass on a random state, then theta on the next; load of the
        // second state starts in the done cycle
        for (int z = 0; z < 64; z++) s[z] = 25'($urandom);
        load_state(s, 1'b1);
        emit_check(s, 2, -1, 1'b0);
        for (int z = 0; z < 64; z++) s[z] = 25'($urandom);
        e = theta_ref(s, 64);
        load_state(s, 1'b0);
        emit_check(e, 2, -1, 1'b0);
        for (int z = 0; z < 64; z++) s[z] = 25'($urandom);
        e = theta_ref(s, 64);
        load_state(s, 1'b0);
        emit_check(e, 0, -1, 1'b0);
        idle_check("t5");

        // 6: reset mid-EMIT at slice 10, then reload case 2
        for (int z = 0; z < 64; z++) begin s[z] = '0; e[z] = '0; end
        s[0] = 25'h0000001;
        e[0] = 25'h0210843;
        e[1] = 25'h1084210;
        load_state(s, 1'b0);
        emit_check(e, 0, 10, 1'b0);
        check("pre_rst_idx", 32'(out_idx), 32'd10);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready",  32'(in_ready),  32'd1);
        check("mid_rst_busy",      32'(busy),      32'd0);
        check("mid_rst_done",      32'(done),      32'd0);
        idle_check("t6_idle");
        load_state(s, 1'b0);
        emit_check(e, 0, -1, 1'b0);
        idle_check("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_keccak_theta_stream
`default_nettype wire
